phase_tuning_estimator: RTL

Recovers the tuning word driving a DDS phase accumulator by observing only its truncated phase output. It sits beside the phase accumulator in the DDS datapath, typically on the debug/readback path. It closes the loop for self-test: the writer side sets `tuning`, and this block reads back the frequency actually being synthesized. Measurement is exact, with no ±1 error, because the window length equals the truncation factor 2^(n-m).

---
 rtl/phase_tuning_estimator.sv | 137 +++++++++++++
 1 files changed

// File: rtl/phase_tuning_estimator.sv
// Recovers a DDS tuning word from the truncated phase output by summing
// wrapped phase deltas over a window of 2^(n-m) cycles.
module phase_tuning_estimator #(
   parameter int unsigned n    = 23,
   parameter int unsigned m    = 14,
   parameter int unsigned tune = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            ce_i,
   input  logic [m-1:0]    phase_in_i,
   input  logic            start_i,
   output logic            busy_o,
   output logic            valid_o,
   output logic            err_o,
   output logic            sat_o,
   output logic [tune-1:0] tuning_est_o
);

   localparam int unsigned CW = n - m;
   localparam int unsigned SW = tune + 1;
   localparam longint unsigned MAX_DELTA = ((64'd1 << tune) - 64'd1) >> CW;
   localparam longint unsigned PHASE_SPAN = 64'd1 << m;

   // A per-cycle delta that can reach 2^m would alias through the wrap.
   if (n <= m || MAX_DELTA >= PHASE_SPAN) begin : g_param_chk
      $error("phase_tuning_estimator: (2^tune-1)/2^(n-m) must be < 2^m and n > m");
   end

   typedef enum logic [1:0] {IDLE, PRIME, MEASURE, DONE} state_t;

   state_t          state_q, state_d;
   logic [m-1:0]    prev_q, prev_d;
   logic [SW-1:0]   sum_q, sum_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic            sat_q, sat_d;
   logic [tune-1:0] est_q, est_d;
   logic [m-1:0]    delta_c;
   logic [SW:0]     acc_c;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         prev_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         sat_q   <= 1'b0;
         est_q   <= '0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         sat_q   <= sat_d;
         est_q   <= est_d;
      end
   end

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      sat_d   = sat_q;
      est_d   = est_q;
      // Modular subtraction makes a wrap through zero look like a normal step.
      delta_c = phase_in_i - prev_q;
      acc_c   = {1'b0, sum_q} + (SW+1)'(delta_c);

      case (state_q)
         IDLE: begin
            if (start_i && ce_i) begin
               sat_d   = 1'b0;
               state_d = PRIME;
            end
         end
         PRIME: begin
            if (!ce_i) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               prev_d  = phase_in_i;
               sum_d   = '0;
               cnt_d   = '0;
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (!ce_i) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               prev_d = phase_in_i;
               cnt_d  = CW'(cnt_q + 1'b1);
               if (acc_c[SW] || acc_c[SW-1]) begin
                  sum_d = '1;
                  sat_d = 1'b1;
               end else begin
                  sum_d = acc_c[SW-1:0];
               end
               if (cnt_q == '1) state_d = DONE;
            end
         end
         DONE: begin
            if (!ce_i) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               est_d   = sat_q ? '1 : sum_q[tune-1:0];
               valid_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign busy_o       = busy_q;
   assign valid_o      = valid_q;
   assign err_o        = err_q;
   assign sat_o        = sat_q;
   assign tuning_est_o = est_q;

endmodule
